// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selector and default geometry.
// Used by every FIFO variant so defaults stay consistent across the family.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  localparam int FIFO_DATA_SIZE = 12;
  localparam int FIFO_ADDR_SIZE = 4;

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Write lands at the edge, read is combinational from raddr; no reset on contents.
module sync_fifo_ram #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with thresholds, occupancy, error pulses, flush, STD/FWFT reads.
// STD read data one edge after rinc, FWFT head shown combinationally; full/empty reject requests.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         DATA_SIZE  = FIFO_DATA_SIZE,
  parameter int         ADDR_SIZE  = FIFO_ADDR_SIZE,
  parameter int         AFULL_LVL  = (1 << ADDR_SIZE) - 2,
  parameter int         AEMPTY_LVL = 2,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 wFull,
  output logic                 wAlmostFull,
  output logic                 rEmpty,
  output logic                 rAlmostEmpty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                 DEPTH    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_W  = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AFULL_W  = (ADDR_SIZE + 1)'(AFULL_LVL);
  localparam logic [ADDR_SIZE:0] AEMPTY_W = (ADDR_SIZE + 1)'(AEMPTY_LVL);
  localparam logic [ADDR_SIZE:0] PTR_ONE  = (ADDR_SIZE + 1)'(1);

  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("sync_fifo: AFULL_LVL outside 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_LVL outside 0..DEPTH-1");
  end

  logic [ADDR_SIZE:0]   wbin_q, wbin_d;
  logic [ADDR_SIZE:0]   rbin_q, rbin_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic [DATA_SIZE-1:0] ram_rdata;
  logic                 wr_acc, rd_acc;

  // Wrap bit makes the modular difference distinguish full from empty.
  assign count        = wbin_q - rbin_q;
  assign wFull        = (count == DEPTH_W);
  assign wAlmostFull  = (count >= AFULL_W);
  assign rEmpty       = (count == '0);
  assign rAlmostEmpty = (count <= AEMPTY_W);

  assign wr_acc = winc & ~wFull & ~flush;
  assign rd_acc = rinc & ~rEmpty & ~flush;

  always_comb begin
    wbin_d      = wbin_q;
    rbin_d      = rbin_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    rdata_d     = rdata_q;
    if (flush) begin
      wbin_d = '0;
      rbin_d = '0;
    end else begin
      if (wr_acc) wbin_d = wbin_q + PTR_ONE;
      if (rd_acc) rbin_d = rbin_q + PTR_ONE;
      overflow_d  = winc & wFull;
      underflow_d = rinc & rEmpty;
      if (MODE == FIFO_STD && rd_acc) rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q      <= '0;
      rbin_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wbin_q      <= wbin_d;
      rbin_q      <= rbin_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rdata_q     <= rdata_d;
    end
  end

  sync_fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wbin_q[ADDR_SIZE-1:0]),
    .wdata (wData),
    .raddr (rbin_q[ADDR_SIZE-1:0]),
    .rdata (ram_rdata)
  );

  assign rData     = (MODE == FIFO_FWFT) ? ram_rdata : rdata_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance and an FWFT instance on shared stimulus.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        winc;
  logic [11:0] wData;
  logic        rinc;

  logic [11:0] rData;
  logic        wFull, wAlmostFull, rEmpty, rAlmostEmpty, overflow, underflow;
  logic [4:0]  count;

  logic [11:0] f_rData;
  logic        f_wFull, f_wAlmostFull, f_rEmpty, f_rAlmostEmpty, f_overflow, f_underflow;
  logic [4:0]  f_count;

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo #(.DATA_SIZE(12), .ADDR_SIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .MODE(FIFO_STD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wData(wData), .rinc(rinc),
    .rData(rData), .wFull(wFull), .wAlmostFull(wAlmostFull), .rEmpty(rEmpty),
    .rAlmostEmpty(rAlmostEmpty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_SIZE(12), .ADDR_SIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .MODE(FIFO_FWFT)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wData(wData), .rinc(rinc),
    .rData(f_rData), .wFull(f_wFull), .wAlmostFull(f_wAlmostFull), .rEmpty(f_rEmpty),
    .rAlmostEmpty(f_rAlmostEmpty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wData = '0;
    #2 rst = 1'b0;
    #3;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
    n_cmp++; if (rEmpty !== 1'b1) begin n_bad++; $display("FAIL reset_rEmpty got=%b want=1", rEmpty); end
    n_cmp++; if (rAlmostEmpty !== 1'b1) begin n_bad++; $display("FAIL reset_rAlmostEmpty got=%b want=1", rAlmostEmpty); end
    n_cmp++; if (wFull !== 1'b0) begin n_bad++; $display("FAIL reset_wFull got=%b want=0", wFull); end
    n_cmp++; if (wAlmostFull !== 1'b0) begin n_bad++; $display("FAIL reset_wAlmostFull got=%b want=0", wAlmostFull); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b want=00", {overflow, underflow}); end
    n_cmp++; if (rData !== 12'h000) begin n_bad++; $display("FAIL reset_rData got=%h want=000", rData); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1; wData = 12'(i);
      tick();
      n_cmp++; if (count !== 5'(i)) begin n_bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i); end
      n_cmp++; if (wAlmostFull !== (i >= 14)) begin n_bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, wAlmostFull, i >= 14); end
      n_cmp++; if (wFull !== (i == 16)) begin n_bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, wFull, i == 16); end
    end
    wData = 12'hEEE;
    tick();
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got=%0d want=16", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    idle();
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_drain();
    for (int j = 1; j <= 16; j++) begin
      rinc = 1'b1;
      tick();
      n_cmp++; if (rData !== 12'(j)) begin n_bad++; $display("FAIL drain_data[%0d] got=%h want=%h", j, rData, 12'(j)); end
      n_cmp++; if (count !== 5'(16 - j)) begin n_bad++; $display("FAIL drain_count[%0d] got=%0d want=%0d", j, count, 16 - j); end
      n_cmp++; if (rAlmostEmpty !== (16 - j <= 2)) begin n_bad++; $display("FAIL drain_aempty[%0d] got=%b want=%b", j, rAlmostEmpty, 16 - j <= 2); end
      n_cmp++; if (rEmpty !== (j == 16)) begin n_bad++; $display("FAIL drain_empty[%0d] got=%b want=%b", j, rEmpty, j == 16); end
    end
    tick();
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL unf_pulse got=%b want=1", underflow); end
    n_cmp++; if (rData !== 12'h010) begin n_bad++; $display("FAIL unf_rData_hold got=%h want=010", rData); end
    idle();
    tick();
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL unf_clear got=%b want=0", underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wData = 12'h100 + 12'(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      winc = 1'b1; rinc = 1'b1; wData = 12'h200 + 12'(i);
      tick();
      n_cmp++; if (count !== 5'd8) begin n_bad++; $display("FAIL b2b_count[%0d] got=%0d want=8", i, count); end
      n_cmp++; if (rData !== 12'h100 + 12'(i)) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, rData, 12'h100 + 12'(i)); end
    end
    idle(); rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (rData !== ((i < 4) ? 12'h104 + 12'(i) : 12'h200 + 12'(i - 4))) begin
        n_bad++; $display("FAIL b2b_order[%0d] got=%h", i, rData);
      end
    end
    idle();
  endtask

  task automatic test_simul_full_empty();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wData = 12'h300 + 12'(i);
      tick();
    end
    winc = 1'b1; rinc = 1'b1; wData = 12'hFFF;
    tick();
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL full_rw_count got=%0d want=15", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_rw_ovf got=%b want=1", overflow); end
    n_cmp++; if (rData !== 12'h300) begin n_bad++; $display("FAIL full_rw_data got=%h want=300", rData); end
    idle(); rinc = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      n_cmp++; if (rData !== 12'h300 + 12'(i)) begin n_bad++; $display("FAIL full_drain[%0d] got=%h want=%h", i, rData, 12'h300 + 12'(i)); end
    end
    winc = 1'b1; rinc = 1'b1; wData = 12'h3AA;
    tick();
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL empty_rw_count got=%0d want=1", count); end
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL empty_rw_unf got=%b want=1", underflow); end
    n_cmp++; if (rData !== 12'h30F) begin n_bad++; $display("FAIL empty_rw_hold got=%h want=30F", rData); end
    winc = 1'b0;
    tick();
    n_cmp++; if (rData !== 12'h3AA) begin n_bad++; $display("FAIL empty_rw_data got=%h want=3AA", rData); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL empty_rw_drain got=%0d want=0", count); end
    idle();
  endtask

  task automatic test_fwft();
    tick();
    n_cmp++; if (f_rEmpty !== 1'b1) begin n_bad++; $display("FAIL fwft_pre_empty got=%b want=1", f_rEmpty); end
    winc = 1'b1; wData = 12'hABC;
    tick();
    idle();
    n_cmp++; if (f_rData !== 12'hABC) begin n_bad++; $display("FAIL fwft_data got=%h want=ABC", f_rData); end
    n_cmp++; if (f_rEmpty !== 1'b0) begin n_bad++; $display("FAIL fwft_empty got=%b want=0", f_rEmpty); end
    n_cmp++; if (f_count !== 5'd1) begin n_bad++; $display("FAIL fwft_count got=%0d want=1", f_count); end
    n_cmp++; if ({f_wFull, f_wAlmostFull, f_rAlmostEmpty} !== 3'b001) begin
      n_bad++; $display("FAIL fwft_flags got=%b want=001", {f_wFull, f_wAlmostFull, f_rAlmostEmpty});
    end
    n_cmp++; if ({f_overflow, f_underflow} !== 2'b00) begin n_bad++; $display("FAIL fwft_pulses got=%b want=00", {f_overflow, f_underflow}); end
    tick();
    n_cmp++; if (f_rData !== 12'hABC) begin n_bad++; $display("FAIL fwft_hold got=%h want=ABC", f_rData); end
    rinc = 1'b1;
    tick();
    idle();
    n_cmp++; if (f_rEmpty !== 1'b1) begin n_bad++; $display("FAIL fwft_pop_empty got=%b want=1", f_rEmpty); end
    n_cmp++; if (rData !== 12'hABC) begin n_bad++; $display("FAIL fwft_std_data got=%h want=ABC", rData); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wData = 12'h500 + 12'(i);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1; rinc = 1'b1; wData = 12'h600 + 12'(i);
      tick();
      n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL wrap_count[%0d] got=%0d want=5", i, count); end
      n_cmp++; if (rData !== ((i < 5) ? 12'h500 + 12'(i) : 12'h600 + 12'(i - 5))) begin
        n_bad++; $display("FAIL wrap_data[%0d] got=%h", i, rData);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      winc = 1'b1; wData = 12'h700 + 12'(i);
      tick();
    end
    idle();
    n_cmp++; if (count !== 5'd9) begin n_bad++; $display("FAIL flush_pre_count got=%0d want=9", count); end
    flush = 1'b1; winc = 1'b1; rinc = 1'b1; wData = 12'h777;
    tick();
    idle();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL flush_count got=%0d want=0", count); end
    n_cmp++; if (rEmpty !== 1'b1) begin n_bad++; $display("FAIL flush_empty got=%b want=1", rEmpty); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL flush_pulses got=%b want=00", {overflow, underflow}); end
    n_cmp++; if (rData !== 12'h622) begin n_bad++; $display("FAIL flush_rData got=%h want=622", rData); end
    n_cmp++; if (f_count !== 5'd0) begin n_bad++; $display("FAIL flush_fwft_count got=%0d want=0", f_count); end
  endtask

  task automatic test_reset_mid();
    winc = 1'b1; wData = 12'h7A1; tick();
    wData = 12'h7A2; tick();
    winc = 1'b0; rinc = 1'b1; tick();
    winc = 1'b1; rinc = 1'b0; wData = 12'h7A3;
    n_cmp++; if (rData !== 12'h7A1) begin n_bad++; $display("FAIL mid_pre_data got=%h want=7A1", rData); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL mid_count got=%0d want=0", count); end
    n_cmp++; if ({rEmpty, rAlmostEmpty} !== 2'b11) begin n_bad++; $display("FAIL mid_empty_flags got=%b want=11", {rEmpty, rAlmostEmpty}); end
    n_cmp++; if ({wFull, wAlmostFull} !== 2'b00) begin n_bad++; $display("FAIL mid_full_flags got=%b want=00", {wFull, wAlmostFull}); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL mid_pulses got=%b want=00", {overflow, underflow}); end
    n_cmp++; if (rData !== 12'h000) begin n_bad++; $display("FAIL mid_rData got=%h want=000", rData); end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simul_full_empty();
    test_fwft();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
